// File: rtl/pipeline_io_responder_pkg.sv
// Shared constants for the MEM-stage I/O responder: register word offsets,
// default window base and the active-low seven-segment glyph table.
package pipeline_io_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FF00;

  localparam int SW_W       = 10;
  localparam int HEX_DIGITS = 6;

  // Word offsets, i.e. addr[7:2]
  localparam logic [5:0] OFF_SW       = 6'h00;
  localparam logic [5:0] OFF_LED      = 6'h01;
  localparam logic [5:0] OFF_HEXVAL   = 6'h02;
  localparam logic [5:0] OFF_HEXBLANK = 6'h03;
  localparam logic [5:0] OFF_SWCHG    = 6'h04;

  // Bit 0 = segment a ... bit 6 = segment g, 0 = lit
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pipeline_io_responder_debounce.sv
// Switch conditioner: 2-flop synchroniser plus per-bit stability counter.
// Pin edge reaches o_stable after DEBOUNCE_CYCLES+2 clocks; o_chg pulses on the updating edge.
module io_debounce #(
  parameter int          W               = 10,
  parameter int          CNT_W           = 16,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_stable,
  output logic [W-1:0] o_chg
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

  logic [W-1:0]     r_meta;
  logic [W-1:0]     r_sync;
  logic [W-1:0]     r_stable;
  logic [CNT_W-1:0] r_cnt [W];
  logic [W-1:0]     w_chg;

  always_comb begin
    w_chg = '0;
    for (int i = 0; i < W; i++) begin
      w_chg[i] = (r_sync[i] != r_stable[i]) && (r_cnt[i] == LAST);
    end
  end

  // A sample equal to the stable value clears the count, so glitches restart it
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_stable <= '0;
      for (int i = 0; i < W; i++) r_cnt[i] <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      for (int i = 0; i < W; i++) begin
        if (r_sync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LAST) begin
          r_stable[i] <= r_sync[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign o_stable = r_stable;
  assign o_chg    = w_chg;

endmodule

// File: rtl/pipeline_io_responder.sv
// MEM-stage I/O responder: LED/7-seg/switch registers in a 256-byte window.
// Loads return one cycle after re (no backpressure); stores take effect on the strobe edge.
module pipeline_io_responder
  import pipeline_io_pkg::*;
#(
  parameter logic [31:0] IO_BASE         = IO_BASE_DEFAULT,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic [9:0]  io_in_sw,
  output logic [9:0]  io_out_led,
  output logic [41:0] io_out_hex
);

  logic [SW_W-1:0]         r_led;
  logic [4*HEX_DIGITS-1:0] r_hexval;
  logic [HEX_DIGITS-1:0]   r_hexblank;
  logic [SW_W-1:0]         r_swchg;
  logic [31:0]             r_rdata;
  logic                    r_rvalid;

  logic                    w_hit;
  logic [5:0]              w_off;
  logic                    w_st;
  logic                    w_ld;
  logic [31:0]             w_rd;
  logic [SW_W-1:0]         w_sw;
  logic [SW_W-1:0]         w_sw_chg;
  logic [SW_W-1:0]         w_swchg_clr;
  logic [41:0]             w_hex;
  logic                    w_unused;

  io_debounce #(
    .W               (SW_W),
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock    (clock),
    .resetn   (resetn),
    .i_raw    (io_in_sw),
    .o_stable (w_sw),
    .o_chg    (w_sw_chg)
  );

  assign w_hit       = (addr[31:8] == IO_BASE[31:8]);
  assign w_off       = addr[7:2];
  assign w_st        = we & w_hit;
  assign w_ld        = re & w_hit;
  assign w_swchg_clr = (w_st && (w_off == OFF_SWCHG)) ? wdata[SW_W-1:0] : '0;
  assign w_unused    = ^{addr[1:0], wdata[31:24]};

  // Reads see pre-store contents, so a same-cycle we/re returns the old value
  always_comb begin
    w_rd = '0;
    case (w_off)
      OFF_SW:       w_rd[SW_W-1:0]         = w_sw;
      OFF_LED:      w_rd[SW_W-1:0]         = r_led;
      OFF_HEXVAL:   w_rd[4*HEX_DIGITS-1:0] = r_hexval;
      OFF_HEXBLANK: w_rd[HEX_DIGITS-1:0]   = r_hexblank;
      OFF_SWCHG:    w_rd[SW_W-1:0]         = r_swchg;
      default:      w_rd = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_led      <= '0;
      r_hexval   <= '0;
      r_hexblank <= '1;
      r_swchg    <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      r_rvalid <= w_ld;
      if (w_ld) r_rdata <= w_rd;
      if (w_st && (w_off == OFF_LED))      r_led      <= wdata[SW_W-1:0];
      if (w_st && (w_off == OFF_HEXVAL))   r_hexval   <= wdata[4*HEX_DIGITS-1:0];
      if (w_st && (w_off == OFF_HEXBLANK)) r_hexblank <= wdata[HEX_DIGITS-1:0];
      // New change events override a simultaneous clear
      r_swchg <= (r_swchg & ~w_swchg_clr) | w_sw_chg;
    end
  end

  always_comb begin
    w_hex = '0;
    for (int k = 0; k < HEX_DIGITS; k++) begin
      w_hex[7*k +: 7] = r_hexblank[k] ? 7'h7F : seg7(r_hexval[4*k +: 4]);
    end
  end

  assign rdata      = r_rdata;
  assign rvalid     = r_rvalid;
  assign io_out_led = r_led;
  assign io_out_hex = w_hex;

endmodule

// File: tb/tb_pipeline_io_responder.sv
// Directed bench for pipeline_io_responder with a short debounce window.
module tb_pipeline_io_responder;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        rvalid;
  logic [9:0]  io_in_sw = '0;
  logic [9:0]  io_out_led;
  logic [41:0] io_out_hex;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_SW    = 32'hFFFF_FF00;
  localparam logic [31:0] A_LED   = 32'hFFFF_FF04;
  localparam logic [31:0] A_HEX   = 32'hFFFF_FF08;
  localparam logic [31:0] A_BLANK = 32'hFFFF_FF0C;
  localparam logic [31:0] A_CHG   = 32'hFFFF_FF10;
  localparam logic [41:0] HEX_OFF = 42'h3FF_FFFF_FFFF;

  pipeline_io_responder #(
    .IO_BASE         (32'hFFFF_FF00),
    .DEBOUNCE_CYCLES (16'd4),
    .CNT_W           (16)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .addr       (addr),
    .wdata      (wdata),
    .we         (we),
    .re         (re),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .io_in_sw   (io_in_sw),
    .io_out_led (io_out_led),
    .io_out_hex (io_out_hex)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    logic        r;
    logic        ev;
    logic [31:0] er;
    logic [9:0]  el;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output logic v, output logic [31:0] d);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    v = rvalid;
    d = rdata;
  endtask

  task automatic load_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic        v;
    logic [31:0] d;
    do_load(a, v, d);
    check({name, " rvalid"}, 64'(v), 64'(1'b1));
    check({name, " rdata"}, 64'(d), 64'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        v;
    logic [31:0] d;

    tbl[0]  = '{A_LED,          32'hFFFF_F3A5, 1'b1, 1'b0, 1'b0, 32'h0,      10'h3A5};
    tbl[1]  = '{A_LED,          32'h0,         1'b0, 1'b1, 1'b1, 32'h3A5,    10'h3A5};
    tbl[2]  = '{A_BLANK,        32'h0,         1'b0, 1'b1, 1'b1, 32'h3F,     10'h3A5};
    tbl[3]  = '{32'h0000_0004,  32'h0,         1'b1, 1'b0, 1'b0, 32'h3F,     10'h3A5};
    tbl[4]  = '{32'h0000_0004,  32'h0,         1'b0, 1'b1, 1'b0, 32'h3F,     10'h3A5};
    tbl[5]  = '{32'hFFFF_FF20,  32'h0,         1'b0, 1'b1, 1'b1, 32'h0,      10'h3A5};
    tbl[6]  = '{A_LED,          32'h001,       1'b1, 1'b0, 1'b0, 32'h0,      10'h001};
    tbl[7]  = '{A_LED,          32'h2AA,       1'b1, 1'b1, 1'b1, 32'h001,    10'h2AA};
    tbl[8]  = '{A_LED,          32'h0,         1'b0, 1'b1, 1'b1, 32'h2AA,    10'h2AA};
    tbl[9]  = '{A_SW,           32'h3FF,       1'b1, 1'b0, 1'b0, 32'h2AA,    10'h2AA};
    tbl[10] = '{A_SW,           32'h0,         1'b0, 1'b1, 1'b1, 32'h0,      10'h2AA};
    tbl[11] = '{32'hFFFF_FF07,  32'h0,         1'b0, 1'b1, 1'b1, 32'h2AA,    10'h2AA};
    tbl[12] = '{A_LED,          32'h0,         1'b0, 1'b0, 1'b0, 32'h2AA,    10'h2AA};
    tbl[13] = '{A_HEX,          32'hFF01_23AF, 1'b1, 1'b0, 1'b0, 32'h2AA,    10'h2AA};
    tbl[14] = '{A_HEX,          32'h0,         1'b0, 1'b1, 1'b1, 32'h0123AF, 10'h2AA};
    tbl[15] = '{A_CHG,          32'h0,         1'b0, 1'b1, 1'b1, 32'h0,      10'h2AA};
    tbl[16] = '{32'hFFFF_FE04,  32'h0,         1'b0, 1'b1, 1'b0, 32'h0,      10'h2AA};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset led", 64'(io_out_led), 64'(10'h0));
    check("reset hex", 64'(io_out_hex), 64'(HEX_OFF));
    check("reset rvalid", 64'(rvalid), 64'(1'b0));
    check("reset rdata", 64'(rdata), 64'(32'h0));
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      addr = tbl[i].a; wdata = tbl[i].d; we = tbl[i].w; re = tbl[i].r;
      tick();
      we = 1'b0; re = 1'b0;
      check($sformatf("vec%0d rvalid", i), 64'(rvalid), 64'(tbl[i].ev));
      check($sformatf("vec%0d rdata", i), 64'(rdata), 64'(tbl[i].er));
      check($sformatf("vec%0d led", i), 64'(io_out_led), 64'(tbl[i].el));
    end

    // Hex decode: HEXVAL = 0x0123AF
    check("hex still blank", 64'(io_out_hex), 64'(HEX_OFF));
    do_store(A_BLANK, 32'h0);
    check("hex unblanked", 64'(io_out_hex),
          64'({7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h0E}));
    do_store(A_BLANK, 32'h1);
    check("hex digit0 blank", 64'(io_out_hex),
          64'({7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h7F}));
    do_store(A_BLANK, 32'h20);
    check("hex digit5 blank", 64'(io_out_hex),
          64'({7'h7F, 7'h79, 7'h24, 7'h30, 7'h08, 7'h0E}));

    // Debounce: a 3-cycle pulse is rejected
    io_in_sw = 10'h008;
    repeat (3) tick();
    io_in_sw = 10'h000;
    repeat (10) tick();
    load_check("glitch sw", A_SW, 32'h0);
    load_check("glitch swchg", A_CHG, 32'h0);

    // Held high: SW[3] visible to a load at edge 7, so updated on edge 6
    io_in_sw = 10'h008;
    for (int k = 1; k <= 7; k++) begin
      do_load(A_SW, v, d);
      check($sformatf("deb edge%0d rvalid", k), 64'(v), 64'(1'b1));
      check($sformatf("deb edge%0d sw", k), 64'(d), (k == 7) ? 64'h8 : 64'h0);
    end
    load_check("swchg set", A_CHG, 32'h8);

    // W1C race: clear lands on the same edge as the falling-edge acceptance
    io_in_sw = 10'h000;
    repeat (5) tick();
    do_store(A_CHG, 32'h8);
    load_check("race sw", A_SW, 32'h0);
    load_check("race swchg", A_CHG, 32'h8);
    do_store(A_CHG, 32'h8);
    load_check("w1c clear", A_CHG, 32'h0);

    // Reset asserted while a load is in flight
    do_store(A_LED, 32'h155);
    do_store(A_BLANK, 32'h0);
    addr = A_LED; re = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check("arst led", 64'(io_out_led), 64'(10'h0));
    check("arst hex", 64'(io_out_hex), 64'(HEX_OFF));
    check("arst rvalid", 64'(rvalid), 64'(1'b0));
    tick();
    re = 1'b0;
    check("arst hold rvalid", 64'(rvalid), 64'(1'b0));
    resetn = 1'b1;
    tick();
    check("post-reset rvalid", 64'(rvalid), 64'(1'b0));
    check("post-reset rdata", 64'(rdata), 64'(32'h0));
    load_check("post-reset blank", A_BLANK, 32'h3F);
    load_check("post-reset led", A_LED, 32'h0);
    load_check("post-reset swchg", A_CHG, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_io_responder.md
Name: pipeline_io_responder

Overview:
Memory-mapped I/O responder on the CPU's MEM-stage data bus, i.e. the device end of the bus whose initiator is the pipelined CPU's memory stage. It decodes word loads and stores in the I/O window and holds the LED and 7-segment state. It synchronises and debounces the board switches and returns read data with a fixed one-cycle latency. Its bus ports connect to the memory-stage address, store data, write strobe and read strobe; the board-pin ports connect to the FPGA top level.

Parameters:
IO_BASE, 32'hFFFF_FF00, base of the 256-byte I/O window; only addr[31:8] is compared against it
DEBOUNCE_CYCLES, 16'd50000, consecutive stable synchronised cycles needed before a switch change is accepted (minimum 2)
CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1

Ports:
clock  in  1  single system clock; all state on rising edge
resetn  in  1  asynchronous, active-low reset
addr  in  32  byte address from the MEM stage
wdata  in  32  store data
we  in  1  store strobe, one cycle per store
re  in  1  load strobe, one cycle per load
rdata  out  32  load data, valid when rvalid=1
rvalid  out  1  one-cycle pulse, exactly one cycle after an accepted re
io_in_sw  in  10  raw asynchronous board switches
io_out_led  out  10  LED drive, active-high
io_out_hex  out  42  six 7-seg digits; digit k = bits [7k+6:7k]; bit 0 = segment a … bit 6 = segment g; active-low

Behaviour:
- Hit = (addr[31:8]==IO_BASE[31:8]). Register offset = addr[7:2]. addr[1:0] ignored; word access only.
- Register map (offset in bytes):
  - 0x00 SW, RO: debounced switches in [9:0], upper bits 0.
  - 0x04 LED, RW: [9:0]; io_out_led = this register.
  - 0x08 HEXVAL, RW: [23:0], six nibbles; nibble k drives digit k.
  - 0x0C HEXBLANK, RW: [5:0]; bit k=1 forces digit k to 7'h7F (all segments off).
  - 0x10 SWCHG, W1C: [9:0] sticky, one bit per switch, set when that debounced bit changes.
- Unmapped hit offsets read 0; stores to them and to SW are ignored. Non-hit we/re are ignored: no rvalid, no state change.
- Store (we & hit): register updates on that edge. io_out_led and io_out_hex reflect the new value from the next cycle.
- Load (re & hit): register contents are sampled on that edge. rdata/rvalid are registered outputs, so rvalid=1 in the next cycle only. Back-to-back loads give back-to-back rvalid.
- When rvalid=0, rdata holds its last value.
- we and re in the same cycle to the same register: the store is performed and the load returns the pre-store value.
- Debounce, per bit:
  - 2-flop synchroniser, then the debounce counter.
  - If sync==stable, counter=0.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, stable<=sync and counter<=0.
  - Any glitch back to the stable value restarts the count.
  - Net latency from pin edge to SW register = DEBOUNCE_CYCLES+2 cycles.
- SWCHG: bit set when its stable value updates. A W1C store clears written 1 bits. If set and clear occur in the same cycle, set wins.
- Hex decode is combinational from HEXVAL/HEXBLANK. Active-low table: 0→7'h40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- Reset (asynchronous, any time including mid-transaction):
  - LED=0, HEXVAL=0, HEXBLANK=6'h3F, SWCHG=0.
  - Synchronisers, stable values and counters = 0.
  - rdata=0, rvalid=0.
  - Hence io_out_hex=42'h3FF_FFFF_FFFF and io_out_led=0.
  - A load pending when reset asserts is dropped (no rvalid after release).

Decomposition:
- Package pipeline_io_pkg: register offset constants, IO_BASE default, 16-entry seven-segment table as a function.
- Sub-module io_debounce (one instance, vector width 10): synchroniser, per-bit counters, stable vector and change pulse.

Test Plan:
- Reset: assert resetn=0 mid-load → io_out_led=0, io_out_hex=42'h3FF_FFFF_FFFF, rvalid=0; after release, load 0x0C returns 32'h3F.
- Write/readback: store 0x3A5 to FFFF_FF04, then load → io_out_led=10'h3A5 next cycle; rdata=32'h3A5, rvalid=1 one cycle after re.
- Hex decode: store 24'h0123AF to 0x08, then store 6'b000000 to 0x0C → digit0=7'h0E, digit1=7'h08, digit2=7'h30, digit5=7'h40. Store 6'b000001 to 0x0C → digit0=7'h7F.
- Debounce (DEBOUNCE_CYCLES=4): pulse sw[3] high for 3 cycles → SW unchanged. Hold it high → SW[3]=1 exactly 6 cycles after the edge, and SWCHG[3]=1.
- SWCHG W1C race: store 32'h8 to 0x10 in the same cycle a new sw[3] change is accepted → SWCHG[3] stays 1. A later store with no race clears it to 0.
- Out-of-window/unmapped: store to 0x0000_0004 → LED unchanged and no rvalid on load. Load from FFFF_FF20 → rdata=0, rvalid=1. Simultaneous we/re to 0x04 (old 0x001, new 0x2AA) → rdata=0x001.
